// File: rtl/instr_encoder_if.sv
// Handshake bus for instr_encoder: field-set input channel, encoded-word output channel
// and the saturating reject counter.
interface instr_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  fmt;
   logic [2:0]  funct3;
   logic        ir30;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [31:0] imm;
   logic        addr_clr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_addr;
   logic [7:0]  err_cnt;

   modport master (
      output in_valid, fmt, funct3, ir30, rd, rs1, rs2, imm, addr_clr, out_ready,
      input  in_ready, out_valid, out_instr, out_addr, err_cnt
   );

   modport slave (
      input  in_valid, fmt, funct3, ir30, rd, rs1, rs2, imm, addr_clr, out_ready,
      output in_ready, out_valid, out_instr, out_addr, err_cnt
   );
endinterface

// File: rtl/instr_encoder.sv
// RV32I field-set encoder: validates and packs one instruction per accept, tags it with
// a running byte address and buffers {instr, addr} in a 2-entry output FIFO.
module instr_encoder (
   input  logic            CLK,
   input  logic            RST,
   instr_encoder_if.slave  bus
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef struct packed {
      logic        legal;
      logic [31:0] word;
   } enc_t;

   function automatic enc_t encode(
      input logic [2:0]  fmt,
      input logic [2:0]  funct3,
      input logic        ir30,
      input logic [4:0]  rd,
      input logic [4:0]  rs1,
      input logic [4:0]  rs2,
      input logic [31:0] imm
   );
      enc_t e;
      e.legal = 1'b1;
      e.word  = '0;
      case (fmt)
         3'd0: begin
            e.word  = {1'b0, ir30, 5'b0, rs2, rs1, funct3, rd, OP_R};
            e.legal = !ir30 || (funct3 == 3'b000) || (funct3 == 3'b101);
         end
         3'd1: begin
            // Shift-immediates carry shamt plus the SRAI select; all others a 12-bit immediate.
            if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
               e.word  = {1'b0, ir30, 5'b0, imm[4:0], rs1, funct3, rd, OP_OPIMM};
               e.legal = !ir30 || (funct3 == 3'b101);
            end else begin
               e.word  = {imm[11:0], rs1, funct3, rd, OP_OPIMM};
            end
         end
         3'd2: begin
            e.word  = {imm[11:0], rs1, funct3, rd, OP_LOAD};
            e.legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
         end
         3'd3: begin
            e.word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
            e.legal = !funct3[2] && (funct3 != 3'b011);
         end
         3'd4: begin
            e.word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
            e.legal = (funct3[2:1] != 2'b01) && !imm[0];
         end
         3'd5: e.word = {imm[31:12], rd, OP_LUI};
         3'd6: e.word = {imm[31:12], rd, OP_AUIPC};
         default: begin
            e.word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            e.legal = !imm[0];
         end
      endcase
      return e;
   endfunction

   logic [1:0][63:0] fifo_q, fifo_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       cnt_q, cnt_d;
   logic [31:0]      addr_q, addr_d;
   logic [7:0]       err_q, err_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;

   enc_t        enc;
   logic        accept;
   logic        push;
   logic        pop;
   logic [31:0] word_addr;

   always_comb begin
      enc       = encode(bus.fmt, bus.funct3, bus.ir30, bus.rd, bus.rs1, bus.rs2, bus.imm);
      accept    = bus.in_valid && in_ready_q;
      push      = accept && enc.legal;
      pop       = out_valid_q && bus.out_ready;
      word_addr = bus.addr_clr ? 32'd0 : addr_q;

      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      err_d    = err_q;

      if (push) begin
         fifo_d[wr_ptr_q] = {enc.word, word_addr};
         wr_ptr_d         = ~wr_ptr_q;
         addr_d           = word_addr + 32'd4;
      end else if (bus.addr_clr) begin
         addr_d = 32'd0;
      end

      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end

      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase

      // Rejected field sets still complete the handshake; they only bump the counter.
      if (accept && !enc.legal && (err_q != 8'hFF)) begin
         err_d = err_q + 8'd1;
      end

      in_ready_d  = (cnt_d != 2'd2);
      out_valid_d = (cnt_d != 2'd0);
   end

   always_ff @(posedge CLK) begin
      fifo_q <= fifo_d;
      if (RST) begin
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         cnt_q       <= 2'd0;
         addr_q      <= 32'd0;
         err_q       <= 8'd0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         err_q       <= err_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   // FIFO storage is never reset, so the visible word is masked whenever nothing is buffered.
   assign bus.out_instr = out_valid_q ? fifo_q[rd_ptr_q][63:32] : 32'd0;
   assign bus.out_addr  = out_valid_q ? fifo_q[rd_ptr_q][31:0]  : 32'd0;
   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.err_cnt   = err_q;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have the following ports, clock and reset first:
  CLK  in  1  system clock; all state changes on rising edge
  RST  in  1  reset, synchronous, active-high
  in_valid  in  1  field set on inputs is valid
  in_ready  out  1  block can accept a field set this cycle
  fmt  in  3  instruction class: 0 R, 1 OP-IMM, 2 LOAD, 3 STORE, 4 BRANCH, 5 LUI, 6 AUIPC, 7 JAL
  funct3  in  3  funct3 field
  ir30  in  1  instruction bit 30 (SUB/SRA/SRAI select)
  rd  in  5  destination register
  rs1  in  5  source register 1
  rs2  in  5  source register 2
  imm  in  32  immediate, unencoded byte value (U-class: bits 31:12 used)
  addr_clr  in  1  clear word-address counter to 0
  out_valid  out  1  out_instr/out_addr valid
  out_ready  in  1  consumer accepts output this cycle
  out_instr  out  32  encoded RV32I machine word
  out_addr  out  32  byte address assigned to out_instr
  err_cnt  out  8  count of rejected field sets, saturating
REQ-002 Clock and reset SHALL be CLK and RST; single clock; RST synchronous, active-high.

Function
REQ-003 Input transfer SHALL occur on a rising edge where in_valid and in_ready are both 1; output transfer where out_valid and out_ready are both 1.
REQ-004 Output buffering SHALL be a 2-entry FIFO of {out_instr, out_addr}; in_ready = 1 iff FIFO holds fewer than 2 entries (registered, no dependence on out_ready).
REQ-005 Latency: a legal word accepted at edge N SHALL appear with out_valid=1 in the cycle after edge N when the FIFO was empty; order preserved.
REQ-006 Simultaneous push and pop with FIFO full SHALL NOT occur (in_ready=0); with 1 entry, push+pop SHALL leave occupancy at 1.
REQ-007 Opcodes: R 0110011, OP-IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111.
REQ-008 R: {0,ir30,00000,rs2,rs1,funct3,rd,op}; ir30 legal only for funct3 000/101.
REQ-009 OP-IMM: funct3 001/101 encode {0,ir30,00000,imm[4:0],rs1,funct3,rd,op}, ir30 legal only for 101; other funct3 encode imm[11:0] in bits 31:20. LOAD: imm[11:0], funct3 000/001/010/100/101 legal.
REQ-010 STORE: {imm[11:5],rs2,rs1,funct3,imm[4:0],op}, funct3 000/001/010 legal.
REQ-011 BRANCH: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],op}; funct3 010/011 illegal; imm[0]=1 illegal.
REQ-012 LUI/AUIPC: {imm[31:12],rd,op}; funct3, rs1, rs2 ignored. JAL: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}; imm[0]=1 illegal.
REQ-013 Fields outside the used range (e.g. imm high bits for I-type) SHALL be ignored, not checked.
REQ-014 Illegal field set: accepted (handshake completes), not pushed, err_cnt += 1, saturating at 255; address counter unchanged.
REQ-015 Address counter: 32-bit, reset 0; each legal accept assigns current value then adds 4; wraps 0xFFFFFFFC -> 0.
REQ-016 addr_clr alone sets counter to 0; addr_clr with a legal accept assigns address 0 to that word and counter becomes 4.
REQ-017 out_instr/out_addr SHALL hold stable while out_valid=1 and out_ready=0.

Reset
REQ-018 RST=1 at an edge SHALL empty the FIFO, clear counter and err_cnt; after that edge out_valid=0, in_ready=1, out_instr=0, out_addr=0, err_cnt=0.
REQ-019 RST SHALL override in-flight transfers in the same cycle; accepted-but-unread words are discarded.

Verification
REQ-020 R add rd=3 rs1=1 rs2=2, then ir30=1 -> 0x002081B3 @addr 0, 0x402081B3 @addr 4.
REQ-021 OP-IMM funct3=000 rd=5 rs1=0 imm=0xFFFFFFFF -> 0xFFF00293; LUI rd=1 imm=0x12345000 -> 0x123450B7.
REQ-022 BRANCH funct3=000 rs1=1 rs2=2 imm=8 -> 0x00208463; JAL rd=1 imm=0x800 -> 0x001000EF.
REQ-023 out_ready=0, three back-to-back legal inputs -> in_ready=0 after second accept, third stalls until first pop; order and addresses 0,4,8 preserved.
REQ-024 BRANCH funct3=010 and JAL imm=1 -> no output, err_cnt=2, next legal word gets addr 0; 300 illegal inputs -> err_cnt=255.
REQ-025 RST asserted with 2 words buffered -> next cycle out_valid=0, in_ready=1; next legal word at addr 0.
